// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on seq_mul_div.op
//   - FSM state enum
//   - width_ok(): elaboration-time sanity check of the operand width
package mul_div_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;  // signed multiply
    localparam logic [1:0] OP_MULU = 2'b01;  // unsigned multiply
    localparam logic [1:0] OP_DIV  = 2'b10;  // signed divide
    localparam logic [1:0] OP_DIVU = 2'b11;  // unsigned divide

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The Booth/restoring datapath assumes at least a few bits of operand.
    function automatic bit width_ok(input int w);
        return (w >= 4);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation (combinational).
//   din  : WIDTH-bit value
//   neg  : 1 -> dout = -din, 0 -> dout = din
//   dout : WIDTH-bit result
// Used for operand magnitudes at accept and for quotient/remainder sign fix-up.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/seq_mul_div.sv
// Iterative multiply/divide unit, one bit per clock.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request an operation (accepted only when busy=0)
//   op       : 00 MUL, 01 MULU, 10 DIV, 11 DIVU
//   a, b     : multiplicand/dividend, multiplier/divisor (captured on accept)
//   busy     : high in RUN and FIX
//   done     : one-cycle pulse, results valid in that cycle
//   lo, hi   : product low/high half, or quotient/remainder
//   div_zero : set when a divide completes with b=0
// Multiply: radix-2 Booth on a (WIDTH+1)-bit accumulator. Divide: restoring
// division on magnitudes with sign correction in FIX.
module seq_mul_div
    import mul_div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("seq_mul_div: WIDTH must be >= 4");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;

    // Captured operation context
    logic [1:0]        op_q;
    logic              a_neg_q, b_neg_q;

    // Shift datapath: acc is the product high part / partial remainder,
    // mq is the multiplier / dividend-then-quotient, aux is the Booth bit.
    logic signed [WIDTH:0] acc;
    logic signed [WIDTH:0] mcand;
    logic [WIDTH-1:0]      mq;
    logic                  aux;

    // Accept-time decode
    logic             accept;
    logic             is_div_in, signed_in, a_neg_in, b_neg_in, div0_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign busy      = (state == RUN) || (state == FIX);
    assign done      = (state == DONE);
    assign accept    = start && !busy;
    assign is_div_in = op[1];
    assign signed_in = !op[0];
    assign a_neg_in  = signed_in && a[WIDTH-1];
    assign b_neg_in  = signed_in && b[WIDTH-1];
    assign div0_in   = is_div_in && (b == '0);

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .din  (a),
        .neg  (is_div_in && a_neg_in),
        .dout (a_mag)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .din  (b),
        .neg  (is_div_in && b_neg_in),
        .dout (b_mag)
    );

    // Per-iteration arithmetic
    logic signed [WIDTH:0] booth_sum;
    logic signed [WIDTH:0] mulu_sum;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH+1:0]      div_diff;

    always_comb begin
        booth_sum = acc;
        case ({mq[0], aux})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        // Booth over WIDTH bits treats the multiplier as signed; for MULU a set
        // multiplier MSB (left in aux) needs one more +a*2^WIDTH step.
        mulu_sum  = acc + mcand;
        div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, mcand};
    end

    // Sign fix-up: quotient negative iff signs differ, remainder follows a.
    logic [WIDTH-1:0] q_fix, r_fix, mul_hi;
    logic             is_sdiv_q;

    assign is_sdiv_q = (op_q == OP_DIV);
    assign mul_hi    = ((op_q == OP_MULU) && aux) ? mulu_sum[WIDTH-1:0] : acc[WIDTH-1:0];

    cond_negate #(.WIDTH(WIDTH)) u_fix_q (
        .din  (mq),
        .neg  (is_sdiv_q && (a_neg_q ^ b_neg_q)),
        .dout (q_fix)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_r (
        .din  (acc[WIDTH-1:0]),
        .neg  (is_sdiv_q && a_neg_q),
        .dout (r_fix)
    );

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = div0_in ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lo       <= '0;
            hi       <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= '0;
                div_zero <= 1'b0;
                if (div0_in) begin
                    lo       <= '1;
                    hi       <= a;
                    div_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX) begin
                if (op_q[1]) begin
                    lo <= q_fix;
                    hi <= r_fix;
                end else begin
                    lo <= mq;
                    hi <= mul_hi;
                end
            end
        end
    end

    // Shift datapath (reset only through the FSM; contents are don't-care until accept)
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            aux     <= 1'b0;
            acc     <= '0;
            if (is_div_in) begin
                mq    <= a_mag;
                mcand <= {1'b0, b_mag};
            end else begin
                mq    <= b;
                mcand <= signed_in ? {a[WIDTH-1], a} : {1'b0, a};
            end
        end else if (state == RUN) begin
            if (op_q[1]) begin
                if (!div_diff[WIDTH+1]) begin
                    acc <= div_diff[WIDTH:0];
                    mq  <= {mq[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= div_shift;
                    mq  <= {mq[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= booth_sum >>> 1;
                mq  <= {booth_sum[0], mq[WIDTH-1:1]};
                aux <= mq[0];
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed-vector bench for seq_mul_div (WIDTH=32).
module tb_seq_mul_div;
    import mul_div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] lo, hi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mul_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .lo       (lo),
        .hi       (hi),
        .div_zero (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation; the following edge is the accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    // Called in cycle 1 after accept; returns the cycle in which done was seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            step();
            lat++;
        end
        if (!done) check("timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                       input logic edz, input int elat);
        int lat, bc;
        issue(o, av, bv, 1'b0);
        wait_done(lat, bc);
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".lo"},  64'(lo),  64'(elo));
        check({tag, ".hi"},  64'(hi),  64'(ehi));
        check({tag, ".dz"},  64'(div_zero), 64'(edz));
        step();
        check({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bc, dcnt;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) step();
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.lo",   64'(lo),   64'd0);
        check("rst.hi",   64'(hi),   64'd0);
        check("rst.dz",   64'(div_zero), 64'd0);
        rst = 1'b0;
        step();

        // MUL -7*6 with full latency and busy window
        issue(OP_MUL, 32'hFFFF_FFF9, 32'd6, 1'b0);
        wait_done(lat, bc);
        check("mul_m7x6.lat",  64'(lat), 64'd34);
        check("mul_m7x6.busy", 64'(bc),  64'd33);
        check("mul_m7x6.busy_done", 64'(busy), 64'd0);
        check("mul_m7x6.hi",   64'(hi),  64'hFFFF_FFFF);
        check("mul_m7x6.lo",   64'(lo),  64'hFFFF_FFD6);
        step();

        run("mulu_ff", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34);
        run("mul_ff",  OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 34);
        run("mulu_msb", OP_MULU, 32'h8000_0000, 32'd2, 32'h0000_0000, 32'h0000_0001, 1'b0, 34);
        run("mul_minmin", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b0, 34);
        run("div_m17_5", OP_DIV, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, 34);
        run("div_17_m5", OP_DIV, 32'd17, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd2, 1'b0, 34);
        run("div_m7_2",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        run("divu_big",  OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34);
        run("div0",      OP_DIV, 32'd42, 32'd0, 32'hFFFF_FFFF, 32'd42, 1'b1, 1);
        run("mul_3x4",   OP_MUL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 34);
        run("div_ovf",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);

        // start pulsed mid-RUN with other operands is ignored
        issue(OP_MUL, 32'd5, 32'd7, 1'b0);
        repeat (5) step();
        op = OP_DIVU; a = 32'd99; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, bc);
        check("ignore.lo", 64'(lo), 64'd35);
        check("ignore.hi", 64'(hi), 64'd0);
        step();

        // reset in cycle 10 of a DIV aborts without a done pulse
        issue(OP_DIV, 32'd1000, 32'd9, 1'b0);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.lo",   64'(lo),   64'd0);
        check("abort.hi",   64'(hi),   64'd0);
        dcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) dcnt++;
            step();
        end
        check("abort.nodone", 64'(dcnt), 64'd0);

        // start held high through DONE: next op accepted back-to-back
        issue(OP_MUL, 32'd3, 32'd5, 1'b1);
        wait_done(lat, bc);
        check("b2b.first.lo", 64'(lo), 64'd15);
        op = OP_DIVU; a = 32'd50; b = 32'd6;
        step();
        start = 1'b0;
        check("b2b.accepted", 64'(busy), 64'd1);
        wait_done(lat, bc);
        check("b2b.lat", 64'(lat), 64'd34);
        check("b2b.lo",  64'(lo),  64'd8);
        check("b2b.hi",  64'(hi),  64'd2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
